// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - registered N-region memory-map decoder with wait states and error capture
module mem_bus_decoder #(
    parameter int ADDR_W = 32,
    parameter int N_REG = 4,
    parameter logic [N_REG*ADDR_W-1:0] REG_BASE = {32'h3004, 32'h3000, 32'h2000, 32'h0},
    parameter logic [N_REG*ADDR_W-1:0] REG_SIZE = {32'h4, 32'h4, 32'h1000, 32'h2000},
    parameter logic [N_REG*4-1:0] REG_WAIT = {4'd0, 4'd0, 4'd1, 4'd0},
    parameter logic [N_REG-1:0] REG_WRITABLE = 4'b0110
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [ADDR_W-1:0]         wdata,
    output logic [ADDR_W-1:0]         rdata,
    output logic                      ready,
    output logic                      err,
    output logic [N_REG-1:0]          cs,
    output logic                      we_out,
    output logic [ADDR_W-1:0]         wdata_out,
    output logic                      rd_stb,
    output logic                      wr_stb,
    input  logic [N_REG*ADDR_W-1:0]   rdata_in,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [7:0]                err_cnt,
    input  logic                      err_clr
);

    localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  sel_q;
    logic [3:0]        wcnt;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [N_REG-1:0]  hit_cs;
    logic [3:0]        hit_wait;
    logic              hit_wr_ok;
    logic [ADDR_W-1:0] sel_rdata;
    logic [7:0]        cnt_base;

    // Region match on the live address; walking downward lets the lowest index win on overlap.
    // Bounds are compared one bit wider so base+size at the top of the map cannot wrap.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        hit_cs    = '0;
        hit_wait  = '0;
        hit_wr_ok = 1'b0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (({1'b0, addr} >= {1'b0, REG_BASE[i*ADDR_W +: ADDR_W]}) &&
                ({1'b0, addr} < ({1'b0, REG_BASE[i*ADDR_W +: ADDR_W]} +
                                 {1'b0, REG_SIZE[i*ADDR_W +: ADDR_W]}))) begin
                hit       = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_cs    = '0;
                hit_cs[i] = 1'b1;
                hit_wait  = REG_WAIT[i*4 +: 4];
                hit_wr_ok = REG_WRITABLE[i];
            end
        end
    end

    // Read-data slice of the region latched for the current access.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_rdata = rdata_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Access FSM; all bus-side outputs are registered and drop at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wcnt      <= '0;
            rdata     <= '0;
            wdata_out <= '0;
            cs        <= '0;
            we_out    <= 1'b0;
            rd_stb    <= 1'b0;
            wr_stb    <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (req) begin
                        addr_q    <= addr;
                        wdata_out <= wdata;
                        if (!hit || (we && !hit_wr_ok)) begin
                            state <= S_ERR;
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            state  <= S_ACCESS;
                            sel_q  <= hit_idx;
                            wcnt   <= hit_wait;
                            cs     <= hit_cs;
                            we_out <= we;
                            // Zero-wait regions strobe in the very first access cycle.
                            if (hit_wait == 4'd0) begin
                                rd_stb <= !we;
                                wr_stb <= we;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                        // Arm the single strobe for the final access cycle.
                        if (wcnt == 4'd1) begin
                            rd_stb <= !we_out;
                            wr_stb <= we_out;
                        end
                    end else begin
                        rd_stb <= 1'b0;
                        wr_stb <= 1'b0;
                        cs     <= '0;
                        we_out <= 1'b0;
                        ready  <= 1'b1;
                        state  <= S_RESP;
                        if (!we_out) begin
                            rdata <= sel_rdata;
                        end
                    end
                end
                S_RESP: begin
                    ready <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A clear in the same cycle as an error is applied first, so the error still counts.
    assign cnt_base = err_clr ? 8'd0 : err_cnt;

    // Error address capture and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= 8'd0;
            err_addr <= '0;
        end else if (state == S_ERR) begin
            err_cnt  <= (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
            err_addr <= addr_q;
        end else if (err_clr) begin
            err_cnt  <= 8'd0;
            err_addr <= '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - self-checking bench for mem_bus_decoder against a region-table model
module tb_mem_bus_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [3:0]   cs;
    logic         we_out;
    logic [31:0]  wdata_out;
    logic         rd_stb;
    logic         wr_stb;
    logic [127:0] rdata_in;
    logic [31:0]  err_addr;
    logic [7:0]   err_cnt;
    logic         err_clr;

    mem_bus_decoder dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .cs(cs), .we_out(we_out),
        .wdata_out(wdata_out), .rd_stb(rd_stb), .wr_stb(wr_stb), .rdata_in(rdata_in),
        .err_addr(err_addr), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    longint base_t [4] = '{64'h0, 64'h2000, 64'h3000, 64'h3004};
    longint size_t [4] = '{64'h2000, 64'h1000, 64'h4, 64'h4};
    int     wait_t [4] = '{0, 1, 0, 0};
    bit     wr_t   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rdata;
    logic [31:0] m_err_addr;
    int          m_err_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        longint la;
        la = longint'({32'b0, a});
        for (int i = 0; i < 4; i++) begin
            if (la >= base_t[i] && la < base_t[i] + size_t[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input bit drop, input bit clr);
        int          r;
        bit          e;
        int          lat;
        logic [3:0]  exp_cs;
        int          n;
        bit          got;
        int          cs_cyc;
        int          rd_n;
        int          wr_n;
        int          stb_cyc;
        logic        err_seen;
        logic [31:0] rdata_seen;
        r      = region_of(a);
        e      = (r < 0) || (w && !wr_t[r]);
        lat    = e ? 1 : wait_t[r] + 2;
        exp_cs = e ? 4'b0 : 4'(1 << r);
        rdata_in = {$urandom, $urandom, $urandom, $urandom};
        req = 1'b1; we = w; addr = a; wdata = d; err_clr = clr;
        @(posedge clk); #1;
        if (drop) begin
            req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        check("rdata_hold", rdata, e ? 32'h0 : m_rdata);
        check("wdata_out", wdata_out, d);
        n = 0; got = 0; cs_cyc = 0; rd_n = 0; wr_n = 0; stb_cyc = 0;
        err_seen = 1'b0; rdata_seen = '0;
        while (!got && n < 40) begin
            n++;
            if (cs != 4'b0) begin
                cs_cyc++;
                check("cs_val", cs, exp_cs);
                check("we_out", we_out, w);
            end
            if (rd_stb) rd_n++;
            if (wr_stb) wr_n++;
            if (rd_stb || wr_stb) stb_cyc = n;
            if (ready) begin
                got = 1; err_seen = err; rdata_seen = rdata;
            end else begin
                @(posedge clk); #1;
            end
        end
        req = 1'b0;
        if (clr) begin
            m_err_cnt = 0; m_err_addr = '0;
        end
        if (e) begin
            m_err_cnt  = (m_err_cnt >= 255) ? 255 : m_err_cnt + 1;
            m_err_addr = a;
            m_rdata    = '0;
        end else if (!w) begin
            m_rdata = rdata_in[r*32 +: 32];
        end
        check("lat", n, got ? lat : -1);
        check("err", err_seen, e);
        check("rdata", rdata_seen, m_rdata);
        check("cs_cycles", cs_cyc, e ? 0 : wait_t[r] + 1);
        check("rd_cnt", rd_n, (!e && !w) ? 1 : 0);
        check("wr_cnt", wr_n, (!e && w) ? 1 : 0);
        check("stb_cyc", stb_cyc, e ? 0 : wait_t[r] + 1);
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("ready_pulse", ready, 1'b0);
        check("rdata_after", rdata, m_rdata);
        check("err_cnt", err_cnt, m_err_cnt);
        check("err_addr", err_addr, m_err_addr);
    endtask

    initial begin
        logic [31:0] ra;
        int          k;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        rdata_in = '0; err_clr = 1'b0;
        m_rdata = '0; m_err_addr = '0; m_err_cnt = 0;
        #1;
        check("rst_cs", cs, 4'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_strobes", {rd_stb, wr_stb, we_out}, 3'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wdata_out", wdata_out, 32'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        check("rst_err_addr", err_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        run_access(1'b1, 32'h0000_2004, 32'h1234_5678, 1'b0, 1'b0);
        run_access(1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0);
        run_access(1'b0, 32'h0000_3004, 32'h0, 1'b1, 1'b0);
        run_access(1'b0, 32'h0000_5000, 32'h0, 1'b0, 1'b0);
        run_access(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 1'b0);
        run_access(1'b1, 32'h0000_3004, 32'h1, 1'b1, 1'b0);
        run_access(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        run_access(1'b1, 32'h0000_2FFF, 32'h55, 1'b1, 1'b0);
        run_access(1'b0, 32'h0000_3008, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: ra = 32'(base_t[k]) + 32'($urandom_range(0, 32'(size_t[k]) - 1));
                1: ra = 32'(base_t[k]);
                2: ra = 32'(base_t[k] + size_t[k] - 1);
                3: ra = 32'(base_t[k] + size_t[k]);
                4: ra = $urandom;
                default: ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            endcase
            run_access(1'($urandom), ra, $urandom, 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        run_access(1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 257; i++) begin
            run_access(1'b0, 32'h0001_0000 + 32'(i * 4), 32'h0, 1'b1, 1'b0);
        end
        check("sat_cnt", err_cnt, 8'hFF);
        run_access(1'b1, 32'h0000_3006, 32'h9, 1'b0, 1'b1);
        check("clr_cnt", err_cnt, 8'h01);

        req = 1'b1; we = 1'b1; addr = 32'h0000_2008; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req = 1'b0;
        check("mid_cs", cs, 4'b0010);
        check("mid_we_out", we_out, 1'b1);
        check("mid_wr_stb0", wr_stb, 1'b0);
        @(posedge clk); #1;
        check("mid_wr_stb1", wr_stb, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs", cs, 4'b0);
        check("arst_we_out", we_out, 1'b0);
        check("arst_wr_stb", wr_stb, 1'b0);
        check("arst_err_cnt", err_cnt, 8'h0);
        check("arst_rdata", rdata, 32'h0);
        m_rdata = '0; m_err_cnt = 0; m_err_addr = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1'b0, 32'h0000_0ABC, 32'h0, 1'b0, 1'b0);
        run_access(1'b0, 32'h0000_2ABC, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
